// File: rtl/proc_run_ctrl.sv
// Run controller for the multi-cycle core: sequences core reset, counts RUN cycles,
// watches IO writes for pass/fail signatures and latches a verdict until restart.
module proc_run_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [31:0] PASS_CODE  = 32'h0000_600D,
    parameter logic [31:0] FAIL_CODE  = 32'h0000_0BAD,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              io_wr_en,
    input  logic [DATA_W-1:0] io_data,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [DATA_W-1:0] last_io
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DATA_W-1:0] PASS_WORD = DATA_W'(PASS_CODE);
    localparam logic [DATA_W-1:0] FAIL_WORD = DATA_W'(FAIL_CODE);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0]  cycle_nxt, wr_nxt;
    logic [DATA_W-1:0] last_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            wr_cnt    <= '0;
            last_io   <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            cycle_cnt <= cycle_nxt;
            wr_cnt    <= wr_nxt;
            last_io   <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        cycle_nxt = cycle_cnt;
        wr_nxt    = wr_cnt;
        last_nxt  = last_io;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Restart outranks any verdict written in the same cycle.
                if (restart) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = '0;
                    cycle_nxt = '0;
                    wr_nxt    = '0;
                    last_nxt  = '0;
                end else begin
                    cycle_nxt = cycle_cnt + 1'b1;
                    if (io_wr_en) begin
                        last_nxt = io_data;
                        if (wr_cnt != '1)
                            wr_nxt = wr_cnt + 1'b1;
                    end
                    if (io_wr_en && io_data == PASS_WORD)
                        state_nxt = ST_PASS;
                    else if (io_wr_en && io_data == FAIL_WORD)
                        state_nxt = ST_FAIL;
                    else if (cycle_cnt == TMO_LAST)
                        state_nxt = ST_TMO;
                end
            end
            ST_PASS, ST_FAIL, ST_TMO: begin
                if (restart) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = '0;
                    cycle_nxt = '0;
                    wr_nxt    = '0;
                    last_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        core_rst  = (state != ST_RUN);
        running   = (state == ST_RUN);
        pass      = (state == ST_PASS);
        fail      = (state == ST_FAIL);
        timed_out = (state == ST_TMO);
        done      = pass | fail | timed_out;
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: instance a (TIMEOUT=16) for most scenarios,
// instance b (CNT_W=4, TIMEOUT=15) for write-count saturation.
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        io_wr_en;
    logic [31:0] io_data;

    logic        a_core_rst, a_running, a_done, a_pass, a_fail, a_timed_out;
    logic [15:0] a_cycle_cnt, a_wr_cnt;
    logic [31:0] a_last_io;
    logic        b_core_rst, b_running, b_done, b_pass, b_fail, b_timed_out;
    logic [3:0]  b_cycle_cnt, b_wr_cnt;
    logic [31:0] b_last_io;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    proc_run_ctrl #(.DATA_W(32), .RST_CYCLES(2), .TIMEOUT(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .restart(restart), .io_wr_en(io_wr_en), .io_data(io_data),
        .core_rst(a_core_rst), .running(a_running), .done(a_done), .pass(a_pass),
        .fail(a_fail), .timed_out(a_timed_out), .cycle_cnt(a_cycle_cnt),
        .wr_cnt(a_wr_cnt), .last_io(a_last_io)
    );

    proc_run_ctrl #(.DATA_W(32), .RST_CYCLES(2), .TIMEOUT(15), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .restart(restart), .io_wr_en(io_wr_en), .io_data(io_data),
        .core_rst(b_core_rst), .running(b_running), .done(b_done), .pass(b_pass),
        .fail(b_fail), .timed_out(b_timed_out), .cycle_cnt(b_cycle_cnt),
        .wr_cnt(b_wr_cnt), .last_io(b_last_io)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling and driving.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_a_flags(input string tag, input logic [5:0] exp);
        check(tag, {58'd0, a_core_rst, a_running, a_done, a_pass, a_fail, a_timed_out},
              {58'd0, exp});
    endtask

    initial begin
        rst = 1'b0; restart = 1'b0; io_wr_en = 1'b0; io_data = '0;
        @(negedge clk);

        // Reset and hold sequence; flags = {core_rst,running,done,pass,fail,timed_out}
        step(3);
        check_a_flags("reset_flags", 6'b100000);
        check("reset_cycle", a_cycle_cnt, 0);
        check("reset_wr", a_wr_cnt, 0);
        check("reset_last", a_last_io, 0);
        rst = 1'b1;
        step(1);
        check_a_flags("hold_edge1", 6'b100000);
        step(1);
        check_a_flags("run_entry", 6'b010000);
        check("run_entry_cycle", a_cycle_cnt, 0);

        // Pass run: 5 at cycle 3, 600D at cycle 7
        step(2);
        io_wr_en = 1'b1; io_data = 32'h5;
        step(1);
        io_wr_en = 1'b0;
        check("c3_cycle", a_cycle_cnt, 3);
        check("c3_wr", a_wr_cnt, 1);
        check("c3_last", a_last_io, 32'h5);
        step(3);
        io_wr_en = 1'b1; io_data = 32'h600D;
        step(1);
        check_a_flags("pass_flags", 6'b101100);
        check("pass_cycle", a_cycle_cnt, 7);
        check("pass_wr", a_wr_cnt, 2);
        check("pass_last", a_last_io, 32'h600D);
        io_data = 32'h0BAD;
        step(2);
        io_wr_en = 1'b0;
        check_a_flags("pass_frozen_flags", 6'b101100);
        check("pass_frozen_wr", a_wr_cnt, 2);
        check("pass_frozen_last", a_last_io, 32'h600D);
        check("pass_frozen_cycle", a_cycle_cnt, 7);

        // Restart from PASS
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_a_flags("restart_hold", 6'b100000);
        check("restart_cycle", a_cycle_cnt, 0);
        check("restart_wr", a_wr_cnt, 0);
        check("restart_last", a_last_io, 0);
        step(1);
        check_a_flags("restart_hold2", 6'b100000);
        step(1);
        check_a_flags("restart_run", 6'b010000);

        // Fail written exactly on the timeout cycle
        step(15);
        check_a_flags("pre_fail_flags", 6'b010000);
        check("pre_fail_cycle", a_cycle_cnt, 15);
        io_wr_en = 1'b1; io_data = 32'h0BAD;
        step(1);
        io_wr_en = 1'b0;
        check_a_flags("fail_flags", 6'b101010);
        check("fail_cycle", a_cycle_cnt, 16);
        check("fail_wr", a_wr_cnt, 1);
        check("fail_last", a_last_io, 32'h0BAD);

        // Timeout with no writes
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(2);
        check_a_flags("tmo_run", 6'b010000);
        step(15);
        check_a_flags("tmo_pre", 6'b010000);
        step(1);
        check_a_flags("tmo_flags", 6'b101001);
        check("tmo_cycle", a_cycle_cnt, 16);
        check("tmo_wr", a_wr_cnt, 0);

        // Restart together with a pass write in RUN
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(2);
        step(2);
        check("rs_pre_cycle", a_cycle_cnt, 2);
        restart = 1'b1; io_wr_en = 1'b1; io_data = 32'h600D;
        step(1);
        restart = 1'b0; io_wr_en = 1'b0;
        check_a_flags("rs_pass_flags", 6'b100000);
        check("rs_pass_cycle", a_cycle_cnt, 0);
        check("rs_pass_wr", a_wr_cnt, 0);
        check("rs_pass_last", a_last_io, 0);
        step(2);
        check_a_flags("rs_rerun", 6'b010000);

        // rst low at RUN cycle 5
        step(4);
        check("mid_pre_cycle", a_cycle_cnt, 4);
        rst = 1'b0; io_wr_en = 1'b1; io_data = 32'h77;
        step(1);
        io_wr_en = 1'b0;
        check_a_flags("mid_rst_flags", 6'b100000);
        check("mid_rst_cycle", a_cycle_cnt, 0);
        check("mid_rst_wr", a_wr_cnt, 0);
        check("mid_rst_last", a_last_io, 0);
        rst = 1'b1;
        step(2);
        check("b_run", {62'd0, b_running, b_core_rst}, 64'b10);

        // Saturation on instance b: 15 consecutive non-signature writes
        io_wr_en = 1'b1;
        for (int unsigned i = 1; i <= 14; i++) begin
            io_data = i;
            step(1);
        end
        check("b_wr14", b_wr_cnt, 14);
        check("b_run14", b_running, 1'b1);
        io_data = 32'd15;
        step(1);
        check("b_wr15", b_wr_cnt, 15);
        check("b_cycle15", b_cycle_cnt, 15);
        check("b_tmo", {60'd0, b_done, b_pass, b_fail, b_timed_out}, 64'b1001);
        check("b_last", b_last_io, 32'd15);
        check("a_wr15", a_wr_cnt, 15);
        check_a_flags("a_still_run", 6'b010000);
        io_data = 32'd3;
        step(2);
        io_wr_en = 1'b0;
        check("b_wr_held", b_wr_cnt, 15);
        check("b_cycle_held", b_cycle_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Parametrised run controller that wraps the multi-cycle processor for self-checking simulation and FPGA bring-up. It sequences the core's reset, counts execution cycles, and watches the memory-mapped IO write port for pass/fail signature words. It reports a latched verdict (pass, fail or timeout), then freezes the core until a restart is requested.

## Interface
Parameters:
- DATA_W, 32, width of the memory-mapped IO word.
- RST_CYCLES, 2, cycles `core_rst` stays high after `rst` is released or a restart; must be >= 1.
- TIMEOUT, 1024, maximum RUN cycles before a timeout verdict; must be >= 1.
- PASS_CODE, 32'h0000_600D, IO word that signals pass (lower DATA_W bits used).
- FAIL_CODE, 32'h0000_0BAD, IO word that signals fail; must differ from PASS_CODE.
- CNT_W, 16, width of `cycle_cnt` and `wr_cnt`; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- restart  input  1  single-cycle request to re-run the core from reset.
- io_wr_en  input  1  core's IO write strobe (mem_wr_en to the IO address).
- io_data  input  DATA_W  core's mem_map_io word.
- core_rst  output  1  active-high reset driven to the processor.
- running  output  1  high while in RUN.
- done  output  1  high in any terminal state.
- pass  output  1  verdict: pass.
- fail  output  1  verdict: fail.
- timed_out  output  1  verdict: timeout.
- cycle_cnt  output  CNT_W  RUN cycles elapsed.
- wr_cnt  output  CNT_W  IO writes seen in RUN, saturating at all-ones.
- last_io  output  DATA_W  most recent IO word written in RUN.

## Operation
- States: HOLD, RUN, PASS, FAIL, TMO. Encoding is free.
- All outputs are registered or decoded from state. `core_rst` = (state != RUN); `running` = RUN; `done` = PASS|FAIL|TMO; `pass`/`fail`/`timed_out` are one-hot with their state.
- Reset (`rst`==0 at an edge): state=HOLD, hold_cnt=0, cycle_cnt=0, wr_cnt=0, last_io=0.
  - Resulting outputs: `core_rst`=1, all other 1-bit outputs 0.
  - `rst` has priority over every other input.
- HOLD:
  - Each edge increments hold_cnt.
  - When hold_cnt==RST_CYCLES-1, go to RUN and clear hold_cnt.
  - `io_wr_en` and `restart` are ignored.
- RUN, per edge:
  - cycle_cnt += 1.
  - If `io_wr_en`: last_io <= io_data, and wr_cnt += 1 unless it is all-ones.
  - If `io_wr_en` and io_data==PASS_CODE, go to PASS.
  - Else if `io_wr_en` and io_data==FAIL_CODE, go to FAIL.
  - Else if cycle_cnt==TIMEOUT-1, go to TMO.
  - A verdict write on the timeout cycle wins; the state goes to PASS or FAIL, not TMO.
- `restart` in RUN aborts the run. Go to HOLD, clear cycle_cnt, wr_cnt and last_io. Restart has priority over a verdict in the same cycle.
- PASS/FAIL/TMO:
  - Terminal. Counters and last_io are frozen and `core_rst`=1 so the core halts.
  - `io_wr_en` is ignored.
  - `restart` goes to HOLD and clears counters and last_io.

## Timing
- After `rst` is sampled high, `core_rst` stays 1 for exactly RST_CYCLES further edges. `running`=1 from the following cycle.
- Verdict latency is 1 cycle: a verdict write sampled at edge k gives `done` and the verdict flag high after edge k. `core_rst` rises at the same edge.
- cycle_cnt counts the verdict cycle.
  - A write in the first RUN cycle yields cycle_cnt=1.
  - A timeout yields cycle_cnt=TIMEOUT.
- Restart latency: `restart` at edge k sets `core_rst`=1 after edge k. RUN is re-entered after edge k+RST_CYCLES.
- `rst` low mid-RUN or in a terminal state returns everything to reset values at that edge.

## Test plan
- Reset/hold, RST_CYCLES=2: hold `rst`=0 for 3 cycles, then release -> `core_rst`=1 for 2 edges after release, then `running`=1 and cycle_cnt=0.
- Pass run:
  - Stimulus: writes 32'h5 at RUN cycle 3, then 32'h600D at cycle 7.
  - Required: `pass`=1, `done`=1, cycle_cnt=7, wr_cnt=2, last_io=32'h600D, `core_rst`=1.
  - Further writes of 32'h0BAD change nothing.
- Fail versus timeout, TIMEOUT=16:
  - 32'h0BAD written exactly on RUN cycle 16 -> `fail`=1, `timed_out`=0, cycle_cnt=16.
  - Same run with no writes -> `timed_out`=1, cycle_cnt=16.
- Restart:
  - `restart` pulsed in PASS -> counters and last_io clear, 2 hold cycles, then RUN.
  - `restart` together with a 32'h600D write in RUN -> HOLD, `pass` stays 0.
- Saturation, CNT_W=4, TIMEOUT=15: 15 non-signature writes in consecutive cycles -> wr_cnt=15 and held there, then `timed_out`=1 with cycle_cnt=15.
- `rst` low in mid-RUN at cycle 5 -> next cycle all outputs at reset values, `core_rst`=1.
